// File: rtl/bcd_mod_counter_pkg.sv
// Shared constants and helpers for the BCD time-keeping counters.
// Parameters are turned into BCD constants here, so the datapath never converts binary to BCD.
package bcd_mod_counter_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 4;

    localparam int unsigned SEC_MOD    = 60;
    localparam int unsigned MIN_MOD    = 60;
    localparam int unsigned HOUR24_MOD = 24;
    localparam int unsigned HOUR12_MOD = 13;
    localparam int unsigned HOUR12_MIN = 1;

    typedef logic [BCD_W-1:0]            bcd_digit_t;
    typedef logic [MAX_DIGITS*BCD_W-1:0] bcd_word_t;

    // Used only on elaboration-time constants.
    function automatic bcd_word_t to_bcd(input int unsigned val);
        bcd_word_t   r;
        int unsigned t;
        r = '0;
        t = val;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            r[i*BCD_W +: BCD_W] = bcd_digit_t'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic digit_valid(input bcd_digit_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control/status bundle of one BCD modulo counter stage.
interface bcd_mod_counter_if #(
    parameter int unsigned DIGITS = 2
);
    import bcd_mod_counter_pkg::*;

    logic                    EN;
    logic                    UP;
    logic                    LOAD;
    logic [BCD_W*DIGITS-1:0] Data;
    logic [BCD_W*DIGITS-1:0] Value;
    logic                    TC;
    logic                    Carry;
    logic                    Borrow;
    logic                    LoadErr;

    modport master (
        output EN, UP, LOAD, Data,
        input  Value, TC, Carry, Borrow, LoadErr
    );

    modport slave (
        input  EN, UP, LOAD, Data,
        output Value, TC, Carry, Borrow, LoadErr
    );

endinterface

// File: rtl/bcd_mod_counter_digit.sv
// One BCD digit: synchronous reset/load, increment/decrement gated by the
// step from the lower digit, and a step output to the next digit.
module bcd_mod_counter_digit
    import bcd_mod_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  bcd_digit_t rst_val,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       step_in,
    input  logic       up,
    output bcd_digit_t q,
    output logic       step_out
);

    bcd_digit_t q_next;

    always_comb begin
        q_next = q;
        if (step_in) begin
            if (up) begin
                q_next = (q == 4'd9) ? '0 : q + 4'd1;
            end else begin
                q_next = (q == 4'd0) ? 4'd9 : q - 4'd1;
            end
        end
    end

    assign step_out = step_in & (up ? (q == 4'd9) : (q == 4'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else if (load) begin
            q <= load_val;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter with up/down, validated parallel load,
// combinational terminal count for cascading and registered wrap pulses.
module bcd_mod_counter
    import bcd_mod_counter_pkg::*;
#(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MODULUS = 60,
    parameter int unsigned MIN_VAL = 0
) (
    input logic              Clk,
    input logic              RST,
    bcd_mod_counter_if.slave bus
);

    localparam int unsigned  W        = BCD_W * DIGITS;
    localparam bcd_word_t    MAX_WORD = to_bcd(MODULUS - 1);
    localparam bcd_word_t    MIN_WORD = to_bcd(MIN_VAL);
    localparam logic [W-1:0] MAX_BCD  = MAX_WORD[W-1:0];
    localparam logic [W-1:0] MIN_BCD  = MIN_WORD[W-1:0];

    logic [W-1:0]      value;
    logic [W-1:0]      ld_val;
    logic [DIGITS-1:0] digit_ok;
    logic [DIGITS:0]   step;
    logic              step_unused;
    logic              at_max;
    logic              at_min;
    logic              above_min;
    logic              data_ok;
    logic              count;
    logic              wrap_up;
    logic              wrap_dn;
    logic              load_ok;
    logic              load_bad;
    logic              digit_load;
    logic              carry_q;
    logic              borrow_q;
    logic              lerr_q;

    always_comb begin
        digit_ok = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit_ok[i] = digit_valid(bus.Data[i*BCD_W +: BCD_W]);
        end
    end

    // With every digit legal, plain vector compare orders BCD words numerically.
    if (MIN_VAL == 0) begin : g_no_min
        assign above_min = 1'b1;
    end else begin : g_min
        assign above_min = (bus.Data >= MIN_BCD);
    end

    assign data_ok  = (&digit_ok) & above_min & (bus.Data <= MAX_BCD);
    assign at_max   = (value == MAX_BCD);
    assign at_min   = (value == MIN_BCD);

    assign count    = bus.EN & ~bus.LOAD;
    assign wrap_up  = count & bus.UP & at_max;
    assign wrap_dn  = count & ~bus.UP & at_min;
    assign load_ok  = bus.LOAD & data_ok;
    assign load_bad = bus.LOAD & ~data_ok;

    // Modulus wraps reuse the digit load path with a constant BCD target.
    assign digit_load = load_ok | wrap_up | wrap_dn;
    assign ld_val     = bus.LOAD ? bus.Data : (bus.UP ? MIN_BCD : MAX_BCD);
    assign step[0]    = count & ~(wrap_up | wrap_dn);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_mod_counter_digit u_digit (
            .clk      (Clk),
            .rst      (RST),
            .rst_val  (MIN_BCD[g*BCD_W +: BCD_W]),
            .load     (digit_load),
            .load_val (ld_val[g*BCD_W +: BCD_W]),
            .step_in  (step[g]),
            .up       (bus.UP),
            .q        (value[g*BCD_W +: BCD_W]),
            .step_out (step[g+1])
        );
    end

    assign step_unused = step[DIGITS];

    always_ff @(posedge Clk) begin
        if (RST) begin
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            carry_q  <= wrap_up;
            borrow_q <= wrap_dn;
            lerr_q   <= load_bad;
        end
    end

    assign bus.Value   = value;
    assign bus.TC      = count & ~RST & ((bus.UP & at_max) | (~bus.UP & at_min));
    assign bus.Carry   = carry_q;
    assign bus.Borrow  = borrow_q;
    assign bus.LoadErr = lerr_q;

endmodule
